// File: rtl/imem_pkg.sv
// Shared types and constants for the runtime-programmable instruction memory.
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } imem_state_t;

    localparam logic [31:0] HLT_WORD = 32'hFC000000;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM: one read or one write per cycle, block-RAM inferable.
module imem_ram #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [BIT_WIDTH-1:0] wdata,
    output logic [BIT_WIDTH-1:0] rdata
);

    logic [BIT_WIDTH-1:0] mem_r [DEPTH];

    // Write port, or registered read when not writing
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end else begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/imem_prog.sv
// Instruction memory with registered fetch port, post-reset hlt sweep and
// streaming host load port; holds the CPU while clearing or loading.
module imem_prog
    import imem_pkg::*;
#(
    parameter int                   BIT_WIDTH = 32,
    parameter int                   DEPTH     = 1024,
    parameter int                   ADDR_W    = $clog2(DEPTH),
    parameter logic [BIT_WIDTH-1:0] FILL_WORD = BIT_WIDTH'(HLT_WORD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_req,
    input  logic [BIT_WIDTH-1:0] fetch_addr,
    output logic [BIT_WIDTH-1:0] fetch_data,
    output logic                 fetch_valid,
    output logic                 fetch_oob,
    output logic                 cpu_hold,
    input  logic                 prog_start,
    input  logic                 prog_end,
    input  logic [BIT_WIDTH-1:0] prog_wdata,
    input  logic                 prog_wvalid,
    output logic                 prog_wready,
    output logic [ADDR_W:0]      prog_count,
    output logic                 prog_full
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    imem_state_t          state_r;
    logic [ADDR_W-1:0]    sweep_r;
    logic [ADDR_W:0]      count_r;
    logic                 valid_r;
    logic                 oob_r;

    logic                 ram_we_s;
    logic [ADDR_W-1:0]    ram_addr_s;
    logic [BIT_WIDTH-1:0] ram_wdata_s;
    logic [BIT_WIDTH-1:0] ram_rdata_s;
    logic                 addr_high_s;
    logic                 load_fire_s;

    assign addr_high_s = |(fetch_addr >> ADDR_W);
    // The load pointer is the low bits of the count; the MSB flags a full memory.
    assign prog_full   = count_r[ADDR_W];
    assign prog_count  = count_r;
    assign prog_wready = (state_r == LOAD) && !prog_full;
    assign load_fire_s = prog_wready && prog_wvalid;
    assign cpu_hold    = (state_r != RUN);
    assign fetch_valid = valid_r;
    assign fetch_oob   = oob_r;

    // RAM port mux: sweep writes in CLEAR, host writes in LOAD, fetch reads in RUN
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = fetch_addr[ADDR_W-1:0];
        ram_wdata_s = prog_wdata;
        case (state_r)
            CLEAR: begin
                ram_we_s    = 1'b1;
                ram_addr_s  = sweep_r;
                ram_wdata_s = FILL_WORD;
            end
            LOAD: begin
                ram_we_s   = load_fire_s;
                ram_addr_s = count_r[ADDR_W-1:0];
            end
            RUN: begin
                ram_we_s = 1'b0;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    // Fetch result select: out-of-range fetches return the fill word
    always_comb begin
        if (!valid_r) begin
            fetch_data = '0;
        end else if (oob_r) begin
            fetch_data = FILL_WORD;
        end else begin
            fetch_data = ram_rdata_s;
        end
    end

    // Control FSM, sweep/load pointers and fetch qualifiers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CLEAR;
            sweep_r <= '0;
            count_r <= '0;
            valid_r <= 1'b0;
            oob_r   <= 1'b0;
        end else begin
            valid_r <= (state_r == RUN) && fetch_req;
            oob_r   <= (state_r == RUN) && fetch_req && addr_high_s;
            case (state_r)
                CLEAR: begin
                    sweep_r <= sweep_r + IDX_ONE;
                    if (sweep_r == LAST_IDX) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (prog_start) begin
                        state_r <= LOAD;
                        count_r <= '0;
                    end
                end
                LOAD: begin
                    if (load_fire_s) begin
                        count_r <= count_r + CNT_ONE;
                    end
                    if (prog_end) begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= CLEAR;
                    sweep_r <= '0;
                end
            endcase
        end
    end

    imem_ram #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

endmodule
